// File: rtl/proc_pkg.sv
// Shared definitions for the 9-bit bus processor and its program sequencer.
//  - CoreWordW     : instruction/data word width used by the processor core
//  - opcode_t      : instruction opcodes, decoded from the top three bits of a word
//  - seq_state_t   : program sequencer states
//  - sat_inc8      : saturating 8-bit increment for the retired-instruction counter
package proc_pkg;

  localparam int unsigned CoreWordW = 9;

  typedef enum logic [2:0] {
    OpMv   = 3'b000,
    OpMvi  = 3'b001,
    OpAdd  = 3'b010,
    OpSub  = 3'b011,
    OpHalt = 3'b111
  } opcode_t;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StWaitI,
    StImmF,
    StWaitD,
    StIssue,
    StExec,
    StNext,
    StHalt
  } seq_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Watchdog for the sequencer's EXEC phase.
// Ports:
//  clk, reset : clock and synchronous active-high reset
//  clear      : force the count back to zero
//  enable     : count this cycle
//  expired    : high in the enabled cycle in which the count reaches all-ones, so a
//               caller that starts counting after a clear sees expired on its
//               (2**TMO_W-1)-th enabled cycle
module seq_watchdog #(
  parameter int unsigned TMO_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TMO_W-1:0] CntLast = ~TMO_W'(1);

  logic [TMO_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != '1)) begin
      cnt_q <= cnt_q + TMO_W'(1);
    end
  end

  // Flag on the increment into all-ones rather than after it, so the owner can act in that
  // same cycle.
  assign expired = enable && (cnt_q == CntLast);

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Program sequencer for the 9-bit bus processor. Fetches instruction words (and the immediate
// word for mvi) from a program ROM, presents them to the core, pulses run and waits for done.
// Supports free-run, single-step and halt, with a watchdog on the core's done response.
// Ports:
//  clk, reset            : clock, synchronous active-high reset
//  start                 : begin execution at PC=0 (only from IDLE or HALT)
//  step_mode, step       : pause after each instruction; step releases one instruction
//  mem_addr, mem_rd      : ROM request (mem_addr always shows the PC)
//  mem_rdata, mem_rvalid : ROM response, variable latency
//  ir_out, din_out       : instruction and immediate to the core
//  run, core_done        : core handshake
//  busy, halted, error   : status; error is a sticky watchdog timeout flag
//  instr_cnt             : retired instructions, saturating at 255
module instr_fetch_sequencer
  import proc_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned WORD_W = CoreWordW,
  parameter int unsigned TMO_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [WORD_W-1:0] ir_out,
  output logic [WORD_W-1:0] din_out,
  output logic              run,
  input  logic              core_done,
  output logic              busy,
  output logic              halted,
  output logic              error,
  output logic [7:0]        instr_cnt
);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] ir_q, ir_d;
  logic [WORD_W-1:0] din_q, din_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;
  // Set once NEXT has been occupied for a full cycle; a step only counts after that.
  logic              paused_q, paused_d;

  logic              wd_clear, wd_enable, wd_expired;
  logic [2:0]        rd_op;

  assign rd_op = mem_rdata[WORD_W-1 -: 3];

  seq_watchdog #(
    .TMO_W(TMO_W)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    din_d     = din_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    paused_d  = paused_q;
    wd_clear  = 1'b0;
    wd_enable = 1'b0;

    unique case (state_q)
      StIdle, StHalt: begin
        if (start) begin
          state_d = StFetch;
          pc_d    = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      StFetch: state_d = StWaitI;
      StWaitI: begin
        if (mem_rvalid) begin
          ir_d = mem_rdata;
          pc_d = pc_q + ADDR_W'(1);
          case (rd_op)
            OpHalt:             state_d = StHalt;
            OpMvi:              state_d = StImmF;
            OpMv, OpAdd, OpSub: state_d = StIssue;
            default: begin
              // Unassigned opcodes retire immediately without involving the core.
              state_d = StNext;
              cnt_d   = sat_inc8(cnt_q);
            end
          endcase
        end
      end
      StImmF: state_d = StWaitD;
      StWaitD: begin
        if (mem_rvalid) begin
          din_d   = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = StIssue;
        end
      end
      StIssue: begin
        wd_clear = 1'b1;
        state_d  = StExec;
      end
      StExec: begin
        wd_enable = 1'b1;
        // A done in the final allowed cycle still wins over the timeout.
        if (core_done) begin
          state_d = StNext;
          cnt_d   = sat_inc8(cnt_q);
        end else if (wd_expired) begin
          state_d = StHalt;
          err_d   = 1'b1;
        end
      end
      StNext: begin
        if (!step_mode || (step && paused_q)) begin
          state_d  = StFetch;
          paused_d = 1'b0;
        end else begin
          paused_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      ir_q     <= '0;
      din_q    <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      paused_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      din_q    <= din_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      paused_q <= paused_d;
    end
  end

  assign mem_addr  = pc_q;
  assign mem_rd    = (state_q == StFetch) || (state_q == StImmF);
  assign run       = (state_q == StIssue);
  assign busy      = (state_q != StIdle) && (state_q != StHalt);
  assign halted    = (state_q == StHalt);
  assign error     = err_q;
  assign instr_cnt = cnt_q;
  assign ir_out    = ir_q;
  assign din_out   = din_q;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
module tb_instr_fetch_sequencer;

  localparam int unsigned AW = 2;

  logic          clk = 1'b0;
  logic          reset, start, step_mode, step;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [8:0]    mem_rdata = '0;
  logic          mem_rvalid = 1'b0;
  logic [8:0]    ir_out, din_out;
  logic          run;
  logic          core_done = 1'b0;
  logic          busy, halted, error;
  logic [7:0]    instr_cnt;

  always #5 clk = ~clk;

  instr_fetch_sequencer #(
    .ADDR_W(AW),
    .WORD_W(9),
    .TMO_W (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .step_mode (step_mode),
    .step      (step),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .mem_rvalid(mem_rvalid),
    .ir_out    (ir_out),
    .din_out   (din_out),
    .run       (run),
    .core_done (core_done),
    .busy      (busy),
    .halted    (halted),
    .error     (error),
    .instr_cnt (instr_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ROM model: one outstanding read, data returned rom_lat cycles after the request.
  logic [8:0]    rom [4];
  int            rom_lat = 1;
  logic          rd_pend = 1'b0;
  int            rd_cnt = 0;
  logic [AW-1:0] rd_addr = '0;

  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    if (rd_pend) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rom[rd_addr];
        rd_pend    = 1'b0;
      end
    end
    if (mem_rd) begin
      rd_pend = 1'b1;
      rd_cnt  = rom_lat;
      rd_addr = mem_addr;
    end
  end

  // Core model: done core_lat cycles after run; core_lat == 0 means never.
  int   core_lat = 1;
  logic c_pend = 1'b0;
  int   c_cnt = 0;

  always @(negedge clk) begin
    core_done = 1'b0;
    if (c_pend) begin
      c_cnt--;
      if (c_cnt == 0) begin
        core_done = 1'b1;
        c_pend    = 1'b0;
      end
    end
    if (run && core_lat != 0) begin
      c_pend = 1'b1;
      c_cnt  = core_lat;
    end
  end

  // Run monitor: counts run pulses and captures what the core was handed.
  int         run_cnt = 0;
  logic [8:0] run_ir = '0;
  logic [8:0] run_din = '0;

  always @(posedge clk) begin
    if (run) begin
      run_cnt <= run_cnt + 1;
      run_ir  <= ir_out;
      run_din <= din_out;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_step;
    step = 1'b1;
    tick(1);
    step = 1'b0;
  endtask

  task automatic wait_halted(input string tag, input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      tick(1);
      n++;
    end
    check_eq(tag, 32'(halted), 32'd1);
  endtask

  task automatic wait_run(input string tag, input int budget);
    int n = 0;
    while (!run && n < budget) begin
      tick(1);
      n++;
    end
    check_eq(tag, 32'(run), 32'd1);
  endtask

  task automatic wait_fetch(input string tag, input int budget);
    int n = 0;
    while (!mem_rd && n < budget) begin
      tick(1);
      n++;
    end
    check_eq(tag, 32'(mem_rd), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    logic [AW-1:0] faddr [5];

    reset = 1'b1;
    start = 1'b0;
    step_mode = 1'b0;
    step = 1'b0;
    for (int i = 0; i < 4; i++) rom[i] = '0;
    tick(3);

    // Reset state
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_halted", 32'(halted), 0);
    check_eq("rst_mem_rd", 32'(mem_rd), 0);
    check_eq("rst_run", 32'(run), 0);
    check_eq("rst_cnt", 32'(instr_cnt), 0);
    check_eq("rst_ir", 32'(ir_out), 0);
    reset = 1'b0;
    tick(2);
    check_eq("idle_busy", 32'(busy), 0);

    // 1: mv R1,R0 ; halt
    rom[0] = 9'o010; rom[1] = 9'o700;
    base = run_cnt;
    pulse_start;
    check_eq("t1_busy", 32'(busy), 1);
    wait_halted("t1_halt", 50);
    check_eq("t1_runs", 32'(run_cnt - base), 1);
    check_eq("t1_run_ir", 32'(run_ir), 32'o010);
    check_eq("t1_ir_held", 32'(ir_out), 32'o700);
    check_eq("t1_cnt", 32'(instr_cnt), 1);
    check_eq("t1_pc", 32'(mem_addr), 2);
    check_eq("t1_busy_end", 32'(busy), 0);

    // 2: mvi R2, 0x5A ; halt (started from HALT)
    rom[0] = 9'o120; rom[1] = 9'h05A; rom[2] = 9'o700;
    base = run_cnt;
    pulse_start;
    wait_halted("t2_halt", 50);
    check_eq("t2_runs", 32'(run_cnt - base), 1);
    check_eq("t2_run_din", 32'(run_din), 32'h05A);
    check_eq("t2_run_ir", 32'(run_ir), 32'o120);
    check_eq("t2_cnt", 32'(instr_cnt), 1);
    check_eq("t2_pc", 32'(mem_addr), 3);
    check_eq("t2_din_held", 32'(din_out), 32'h05A);

    // 4: core never done -> timeout after 15 EXEC cycles
    rom[0] = 9'o200; rom[1] = 9'o700;
    core_lat = 0;
    base = run_cnt;
    pulse_start;
    wait_run("t4_run", 20);
    n = 0;
    while (!halted && n < 40) begin
      tick(1);
      n++;
    end
    check_eq("t4_tmo_cycles", 32'(n), 16);
    check_eq("t4_error", 32'(error), 1);
    check_eq("t4_cnt", 32'(instr_cnt), 0);
    check_eq("t4_runs", 32'(run_cnt - base), 1);
    core_lat = 1;
    pulse_start;
    check_eq("t4_err_clr", 32'(error), 0);
    wait_halted("t4_halt2", 50);
    check_eq("t4_err_end", 32'(error), 0);
    check_eq("t4_cnt2", 32'(instr_cnt), 1);

    // 3: single-step add/sub/add/halt
    rom[0] = 9'o200; rom[1] = 9'o300; rom[2] = 9'o200; rom[3] = 9'o700;
    step_mode = 1'b1;
    base = run_cnt;
    pulse_start;
    wait_run("t3_run1", 20);
    tick(2);
    // First cycle in NEXT: this step must not release the pause.
    pulse_step;
    tick(20);
    check_eq("t3_entry_step", 32'(run_cnt - base), 1);
    check_eq("t3_busy_paused", 32'(busy), 1);
    pulse_step;
    tick(10);
    check_eq("t3_step2", 32'(run_cnt - base), 2);
    tick(10);
    check_eq("t3_no_free_run", 32'(run_cnt - base), 2);
    pulse_step;
    tick(10);
    check_eq("t3_step3", 32'(run_cnt - base), 3);
    pulse_step;
    wait_halted("t3_halt", 20);
    check_eq("t3_runs", 32'(run_cnt - base), 3);
    check_eq("t3_cnt", 32'(instr_cnt), 3);
    step_mode = 1'b0;

    // 5: all mv, PC wrap and counter saturation
    for (int i = 0; i < 4; i++) rom[i] = 9'o010;
    pulse_start;
    for (int i = 0; i < 5; i++) begin
      wait_fetch("t5_fetch", 20);
      faddr[i] = mem_addr;
      tick(1);
    end
    check_eq("t5_addr3", 32'(faddr[3]), 3);
    check_eq("t5_wrap", 32'(faddr[4]), 0);
    n = 0;
    while (instr_cnt != 8'd255 && n < 2000) begin
      tick(1);
      n++;
    end
    check_eq("t5_reach255", 32'(instr_cnt), 255);
    tick(60);
    check_eq("t5_sat", 32'(instr_cnt), 255);
    check_eq("t5_busy", 32'(busy), 1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;

    // 6: reset during WAIT_D with a ROM response still pending
    rom[0] = 9'o120; rom[1] = 9'h05A; rom[2] = 9'o700;
    rom_lat = 3;
    pulse_start;
    tick(1);
    wait_fetch("t6_immf", 20);
    check_eq("t6_imm_addr", 32'(mem_addr), 1);
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_eq("t6_busy", 32'(busy), 0);
    check_eq("t6_ir", 32'(ir_out), 0);
    check_eq("t6_addr", 32'(mem_addr), 0);
    check_eq("t6_mem_rd", 32'(mem_rd), 0);
    check_eq("t6_cnt", 32'(instr_cnt), 0);
    tick(5);
    check_eq("t6_late_din", 32'(din_out), 0);
    check_eq("t6_late_busy", 32'(busy), 0);
    check_eq("t6_late_halted", 32'(halted), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
